// File: rtl/mipi_csi_pkg.sv
// Shared definitions for the CSI-2 packet parser.
// No ports. Provides data type codes, CRC constants, the parser state enum
// and the header ECC function.
package mipi_csi_pkg;

   localparam logic [5:0] DT_FS        = 6'h00;
   localparam logic [5:0] DT_FE        = 6'h01;
   localparam logic [5:0] DT_LS        = 6'h02;
   localparam logic [5:0] DT_LE        = 6'h03;
   localparam logic [5:0] DT_SHORT_MAX = 6'h0F;
   localparam logic [5:0] DT_RAW8      = 6'h2A;
   localparam logic [5:0] DT_RAW10     = 6'h2B;

   localparam logic [15:0] CRC_POLY_REFL = 16'h8408;
   localparam logic [15:0] CRC_INIT      = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAYLOAD,
      ST_CRC,
      ST_DRAIN
   } state_t;

   // CSI-2 header ECC over D[23:0] = {WC_MSB, WC_LSB, DI}; bits 7:6 are always 0.
   function automatic logic [7:0] csi_ecc(input logic [23:0] d);
      logic [7:0] e;
      e    = '0;
      e[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
      e[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
      e[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
      e[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
      e[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
      e[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
      return e;
   endfunction

endpackage

// File: rtl/mipi_csi_pkt_parser_if.sv
// Byte stream in and parsed header / payload / status out of the CSI-2 parser.
// Ports: in_we/in_data from the deserializer; hdr_*, fs/fe/ls/le, pay_*,
// pkt_done/crc_err, ecc_err, trunc_err toward the unpacker. No backpressure.
interface mipi_csi_pkt_parser_if;

   logic        in_we;
   logic [7:0]  in_data;
   logic        hdr_valid;
   logic [1:0]  hdr_vc;
   logic [5:0]  hdr_dt;
   logic [15:0] hdr_wc;
   logic        fs;
   logic        fe;
   logic        ls;
   logic        le;
   logic        pay_valid;
   logic [7:0]  pay_data;
   logic        pay_first;
   logic        pay_last;
   logic        pkt_done;
   logic        crc_err;
   logic        ecc_err;
   logic        trunc_err;

   // Byte source side (deserializer / bench).
   modport master (
      output in_we, in_data,
      input  hdr_valid, hdr_vc, hdr_dt, hdr_wc, fs, fe, ls, le,
      input  pay_valid, pay_data, pay_first, pay_last,
      input  pkt_done, crc_err, ecc_err, trunc_err
   );

   // Parser side.
   modport slave (
      input  in_we, in_data,
      output hdr_valid, hdr_vc, hdr_dt, hdr_wc, fs, fe, ls, le,
      output pay_valid, pay_data, pay_first, pay_last,
      output pkt_done, crc_err, ecc_err, trunc_err
   );

endinterface

// File: rtl/mipi_csi_crc16.sv
// Byte-wide CRC-16 (reflected poly 0x8408) next-state, purely combinational.
// Ports: crc_in current CRC, data byte (consumed LSB first), crc_out next CRC.
// Zero latency; no flow control.
module mipi_csi_crc16
   import mipi_csi_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data,
   output logic [15:0] crc_out
);

   logic [15:0] c;

   always_comb begin
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY_REFL;
         else                c = c >> 1;
      end
      crc_out = c;
   end

endmodule

// File: rtl/mipi_csi_pkt_parser.sv
// CSI-2 packet parser: header/ECC check, short-packet sync pulses, payload
// streaming with first/last markers and payload CRC check.
// Ports: clk, resetb (async active-low), bus (slave modport). All outputs are
// registered, 1 cycle after the accepted byte; no backpressure on the input.
module mipi_csi_pkt_parser
   import mipi_csi_pkg::*;
#(
   parameter bit CHECK_ECC = 1'b1,
   parameter bit CHECK_CRC = 1'b1
)(
   input  logic                        clk,
   input  logic                        resetb,
   mipi_csi_pkt_parser_if.slave        bus
);

   state_t      state, state_nxt;
   logic [7:0]  di;
   logic [7:0]  wc_lsb;
   logic [15:0] wc;
   logic [1:0]  cnt;        // header byte index, reused as CRC byte index
   logic [15:0] remaining;
   logic [15:0] crc;
   logic [15:0] crc_nxt;
   logic [7:0]  crc_lsb;

   logic        we;
   logic [7:0]  din;
   logic        ecc_ok;
   logic        hdr_accept;
   logic        is_short;

   logic        hdr_valid_n, fs_n, fe_n, ls_n, le_n;
   logic [1:0]  hdr_vc_n;
   logic [5:0]  hdr_dt_n;
   logic [15:0] hdr_wc_n;
   logic        pay_valid_n, pay_first_n, pay_last_n;
   logic [7:0]  pay_data_n;
   logic        pkt_done_n, crc_err_n, ecc_err_n, trunc_err_n;

   assign we  = bus.in_we;
   assign din = bus.in_data;

   // WC MSB is latched the cycle before the ECC byte, so the full header is in flops here.
   assign ecc_ok     = (csi_ecc({wc, di}) == din);
   assign hdr_accept = ecc_ok || !CHECK_ECC;
   assign is_short   = (di[5:0] <= DT_SHORT_MAX);

   mipi_csi_crc16 u_crc (
      .crc_in  (crc),
      .data    (din),
      .crc_out (crc_nxt)
   );

   // State register
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:    if (we) state_nxt = ST_HDR;
         ST_HDR: begin
            if (!we)
               state_nxt = ST_IDLE;
            else if (cnt == 2'd3) begin
               if (!hdr_accept || is_short) state_nxt = ST_DRAIN;
               else if (wc == 16'd0)        state_nxt = ST_CRC;
               else                         state_nxt = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (!we)                      state_nxt = ST_IDLE;
            else if (remaining == 16'd1)  state_nxt = ST_CRC;
         end
         ST_CRC: begin
            if (!we)               state_nxt = ST_IDLE;
            else if (cnt == 2'd1)  state_nxt = ST_DRAIN;
         end
         ST_DRAIN:   if (!we) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Output decode (registered below)
   always_comb begin
      hdr_valid_n = 1'b0;
      hdr_vc_n    = '0;
      hdr_dt_n    = '0;
      hdr_wc_n    = '0;
      fs_n        = 1'b0;
      fe_n        = 1'b0;
      ls_n        = 1'b0;
      le_n        = 1'b0;
      pay_valid_n = 1'b0;
      pay_data_n  = '0;
      pay_first_n = 1'b0;
      pay_last_n  = 1'b0;
      pkt_done_n  = 1'b0;
      crc_err_n   = 1'b0;
      ecc_err_n   = 1'b0;
      trunc_err_n = 1'b0;
      unique case (state)
         ST_HDR: begin
            if (!we)
               trunc_err_n = 1'b1;
            else if (cnt == 2'd3) begin
               ecc_err_n = !ecc_ok;
               if (hdr_accept) begin
                  hdr_valid_n = 1'b1;
                  hdr_vc_n    = di[7:6];
                  hdr_dt_n    = di[5:0];
                  hdr_wc_n    = wc;
                  fs_n        = (di[5:0] == DT_FS);
                  fe_n        = (di[5:0] == DT_FE);
                  ls_n        = (di[5:0] == DT_LS);
                  le_n        = (di[5:0] == DT_LE);
               end
            end
         end
         ST_PAYLOAD: begin
            if (!we)
               trunc_err_n = 1'b1;
            else begin
               pay_valid_n = 1'b1;
               pay_data_n  = din;
               pay_first_n = (remaining == wc);
               pay_last_n  = (remaining == 16'd1);
            end
         end
         ST_CRC: begin
            if (!we)
               trunc_err_n = 1'b1;
            else if (cnt == 2'd1) begin
               pkt_done_n = 1'b1;
               crc_err_n  = CHECK_CRC && ({din, crc_lsb} != crc);
            end
         end
         default: ;
      endcase
   end

   // Header / payload datapath
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         di        <= '0;
         wc_lsb    <= '0;
         wc        <= '0;
         cnt       <= '0;
         remaining <= '0;
         crc       <= '0;
         crc_lsb   <= '0;
      end else if (we) begin
         unique case (state)
            ST_IDLE: begin
               di  <= din;
               cnt <= 2'd1;
            end
            ST_HDR: begin
               unique case (cnt)
                  2'd1: begin wc_lsb <= din;            cnt <= 2'd2; end
                  2'd2: begin wc     <= {din, wc_lsb};  cnt <= 2'd3; end
                  2'd3: begin
                     crc       <= CRC_INIT;
                     remaining <= wc;
                     cnt       <= 2'd0;
                  end
                  default: cnt <= 2'd0;
               endcase
            end
            ST_PAYLOAD: begin
               crc       <= crc_nxt;
               remaining <= remaining - 16'd1;
            end
            ST_CRC: begin
               if (cnt == 2'd0) begin
                  crc_lsb <= din;
                  cnt     <= 2'd1;
               end else begin
                  cnt     <= 2'd0;
               end
            end
            default: ;
         endcase
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         bus.hdr_valid <= 1'b0;
         bus.hdr_vc    <= '0;
         bus.hdr_dt    <= '0;
         bus.hdr_wc    <= '0;
         bus.fs        <= 1'b0;
         bus.fe        <= 1'b0;
         bus.ls        <= 1'b0;
         bus.le        <= 1'b0;
         bus.pay_valid <= 1'b0;
         bus.pay_data  <= '0;
         bus.pay_first <= 1'b0;
         bus.pay_last  <= 1'b0;
         bus.pkt_done  <= 1'b0;
         bus.crc_err   <= 1'b0;
         bus.ecc_err   <= 1'b0;
         bus.trunc_err <= 1'b0;
      end else begin
         bus.hdr_valid <= hdr_valid_n;
         bus.hdr_vc    <= hdr_vc_n;
         bus.hdr_dt    <= hdr_dt_n;
         bus.hdr_wc    <= hdr_wc_n;
         bus.fs        <= fs_n;
         bus.fe        <= fe_n;
         bus.ls        <= ls_n;
         bus.le        <= le_n;
         bus.pay_valid <= pay_valid_n;
         bus.pay_data  <= pay_data_n;
         bus.pay_first <= pay_first_n;
         bus.pay_last  <= pay_last_n;
         bus.pkt_done  <= pkt_done_n;
         bus.crc_err   <= crc_err_n;
         bus.ecc_err   <= ecc_err_n;
         bus.trunc_err <= trunc_err_n;
      end
   end

endmodule
